// File: rtl/ctrl_pkg.sv
// Opcode, state and ACC-mux encodings shared by controller_fsm_mc and ctrl_decode.
// Optional macro CTRL_CARRY_JUMPS_EN makes the carry jumps (9, E) legal.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_ADD        = 4'h1;
  localparam logic [3:0] OP_SUB        = 4'h2;
  localparam logic [3:0] OP_NOR        = 4'h3;
  localparam logic [3:0] OP_REG_TO_ACC = 4'h4;
  localparam logic [3:0] OP_ACC_TO_REG = 4'h5;
  localparam logic [3:0] OP_JMPZ_REG   = 4'h6;
  localparam logic [3:0] OP_JMPZ_IMM   = 4'h7;
  localparam logic [3:0] OP_JMPNZ_REG  = 4'h8;
  localparam logic [3:0] OP_JMPNZ_IMM  = 4'hA;
  localparam logic [3:0] OP_SHFL       = 4'hB;
  localparam logic [3:0] OP_SHFR       = 4'hC;
  localparam logic [3:0] OP_IMM_TO_ACC = 4'hD;
  localparam logic [3:0] OP_HALT       = 4'hF;
`ifdef CTRL_CARRY_JUMPS_EN
  localparam logic [3:0] OP_JMPC_IMM   = 4'h9;
  localparam logic [3:0] OP_JMPNC_IMM  = 4'hE;
`endif

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALTED = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  localparam logic [1:0] ACC_IMM = 2'b00;
  localparam logic [1:0] ACC_REG = 2'b01;
  localparam logic [1:0] ACC_ALU = 2'b11;

  // Opcode arrives zero-extended to 32 bits; any set upper bit is illegal.
  function automatic logic is_legal_op(input logic [31:0] op);
    logic [3:0] lo;
    lo = op[3:0];
    is_legal_op = 1'b0;
    if (op[31:4] == 28'd0) begin
      case (lo)
        OP_NOP, OP_ADD, OP_SUB, OP_NOR, OP_REG_TO_ACC, OP_ACC_TO_REG,
        OP_JMPZ_REG, OP_JMPZ_IMM, OP_JMPNZ_REG, OP_JMPNZ_IMM,
        OP_SHFL, OP_SHFR, OP_IMM_TO_ACC, OP_HALT: is_legal_op = 1'b1;
`ifdef CTRL_CARRY_JUMPS_EN
        OP_JMPC_IMM, OP_JMPNC_IMM:               is_legal_op = 1'b1;
`endif
        default:                                 is_legal_op = 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational EXEC-phase decode: latched opcode and flags to datapath controls.
// Carry jumps are decoded only when CTRL_CARRY_JUMPS_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 4
) (
  input  logic [OPC_W-1:0] op_i,
  input  logic             zf_i,
`ifdef CTRL_CARRY_JUMPS_EN
  input  logic             cf_i,
`endif
  output logic             load_pc_o,
  output logic             sel_pc_o,
  output logic             load_reg_o,
  output logic             load_acc_o,
  output logic [1:0]       sel_acc_o,
  output logic [OPC_W-1:0] sel_alu_o,
  output logic             flag_we_o
);

  logic take;
  logic jmp_imm;

  always_comb begin
    load_pc_o  = 1'b0;
    sel_pc_o   = 1'b0;
    load_reg_o = 1'b0;
    load_acc_o = 1'b0;
    sel_acc_o  = ACC_IMM;
    sel_alu_o  = OPC_W'(OP_NOP);
    flag_we_o  = 1'b0;
    take       = 1'b0;
    jmp_imm    = 1'b0;
    case (op_i)
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_NOR),
      OPC_W'(OP_SHFL), OPC_W'(OP_SHFR): begin
        load_acc_o = 1'b1;
        sel_acc_o  = ACC_ALU;
        sel_alu_o  = op_i;
        flag_we_o  = 1'b1;
      end
      OPC_W'(OP_REG_TO_ACC): begin
        load_acc_o = 1'b1;
        sel_acc_o  = ACC_REG;
      end
      OPC_W'(OP_IMM_TO_ACC): load_acc_o = 1'b1;
      OPC_W'(OP_ACC_TO_REG): load_reg_o = 1'b1;
      OPC_W'(OP_JMPZ_REG):   take = zf_i;
      OPC_W'(OP_JMPZ_IMM):   begin take = zf_i;  jmp_imm = 1'b1; end
      OPC_W'(OP_JMPNZ_REG):  take = ~zf_i;
      OPC_W'(OP_JMPNZ_IMM):  begin take = ~zf_i; jmp_imm = 1'b1; end
`ifdef CTRL_CARRY_JUMPS_EN
      OPC_W'(OP_JMPC_IMM):   begin take = cf_i;  jmp_imm = 1'b1; end
      OPC_W'(OP_JMPNC_IMM):  begin take = ~cf_i; jmp_imm = 1'b1; end
`endif
      default: ;
    endcase
    // A not-taken jump leaves every control at its idle value.
    if (take) begin
      load_pc_o = 1'b1;
      sel_pc_o  = jmp_imm;
      sel_alu_o = op_i;
    end
  end

endmodule

// File: rtl/controller_fsm_mc.sv
// Multi-cycle FETCH/DECODE/EXEC accumulator controller with imem handshake, HALT/resume and trap.
// Optional macro CTRL_CARRY_JUMPS_EN enables JMPC_IMM / JMPNC_IMM.
module controller_fsm_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W         = 4,
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter int unsigned TMO_W         = 4
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic [OPC_W-1:0] Opcode,
  input  logic             Z,
  input  logic             C,
  input  logic             imem_ack,
  input  logic             resume,
  output logic             imem_req,
  output logic             LoadIR,
  output logic             IncPC,
  output logic             SelPC,
  output logic             LoadPC,
  output logic             LoadReg,
  output logic             LoadAcc,
  output logic [1:0]       SelAcc,
  output logic [OPC_W-1:0] SelALU,
  output logic             halted,
  output logic             illegal_op
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(FETCH_TIMEOUT);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic             zf_q, zf_d, cf_q, cf_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic             dec_load_pc, dec_sel_pc, dec_load_reg, dec_load_acc, dec_flag_we;
  logic [1:0]       dec_sel_acc;
  logic [OPC_W-1:0] dec_sel_alu;

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .op_i       (op_q),
    .zf_i       (zf_q),
`ifdef CTRL_CARRY_JUMPS_EN
    .cf_i       (cf_q),
`endif
    .load_pc_o  (dec_load_pc),
    .sel_pc_o   (dec_sel_pc),
    .load_reg_o (dec_load_reg),
    .load_acc_o (dec_load_acc),
    .sel_acc_o  (dec_sel_acc),
    .sel_alu_o  (dec_sel_alu),
    .flag_we_o  (dec_flag_we)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      op_q    <= OPC_W'(OP_NOP);
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    cnt_d   = '0;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
          if ((FETCH_TIMEOUT != 0) && (cnt_d == TMO_LIM)) state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        op_d = Opcode;
        if (Opcode == OPC_W'(OP_HALT))      state_d = ST_HALTED;
        else if (!is_legal_op(32'(Opcode))) state_d = ST_TRAP;
        else                                state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (dec_flag_we) begin
          zf_d = Z;
          cf_d = C;
        end
      end
      ST_HALTED: if (resume) state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_TRAP;
    endcase
  end

  // FETCH outputs are gated by reset_n so nothing fires while reset is held.
  always_comb begin
    imem_req   = 1'b0;
    LoadIR     = 1'b0;
    IncPC      = 1'b0;
    SelPC      = 1'b0;
    LoadPC     = 1'b0;
    LoadReg    = 1'b0;
    LoadAcc    = 1'b0;
    SelAcc     = ACC_IMM;
    SelALU     = OPC_W'(OP_NOP);
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = reset_n;
        LoadIR   = reset_n & imem_ack;
        IncPC    = reset_n & imem_ack;
      end
      ST_EXEC: begin
        SelPC   = dec_sel_pc;
        LoadPC  = dec_load_pc;
        LoadReg = dec_load_reg;
        LoadAcc = dec_load_acc;
        SelAcc  = dec_sel_acc;
        SelALU  = dec_sel_alu;
      end
      ST_HALTED: halted     = 1'b1;
      ST_TRAP:   illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller_fsm_mc.sv
// Directed bench for controller_fsm_mc: fetch handshake, ALU/jump decode, HALT/resume, timeout and trap.
module tb_controller_fsm_mc;
  import ctrl_pkg::*;

  localparam int unsigned OPC_W = 4;

  logic             Clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [OPC_W-1:0] Opcode = '0;
  logic             Z = 1'b0, C = 1'b0, imem_ack = 1'b0, resume = 1'b0;
  logic             imem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, halted, illegal_op;
  logic [1:0]       SelAcc;
  logic [OPC_W-1:0] SelALU;

  int total = 0;
  int bad   = 0;

  // Observed control vector: {req, ir, inc, selpc, ldpc, ldreg, ldacc, selacc[1:0], halted, illegal}
  localparam logic [10:0] B_REQ     = 11'h400;
  localparam logic [10:0] B_IR      = 11'h200;
  localparam logic [10:0] B_INC     = 11'h100;
  localparam logic [10:0] B_SELPC   = 11'h080;
  localparam logic [10:0] B_LDPC    = 11'h040;
  localparam logic [10:0] B_LDREG   = 11'h020;
  localparam logic [10:0] B_LDACC   = 11'h010;
  localparam logic [10:0] B_ACC_ALU = 11'h00C;
  localparam logic [10:0] B_ACC_REG = 11'h004;
  localparam logic [10:0] B_HALT    = 11'h002;
  localparam logic [10:0] B_ILL     = 11'h001;
  localparam logic [10:0] V_FETCH_ACK = B_REQ | B_IR | B_INC;
  localparam logic [10:0] V_ALU       = B_LDACC | B_ACC_ALU;
  localparam logic [10:0] V_JIMM      = B_SELPC | B_LDPC;

  controller_fsm_mc #(.OPC_W(OPC_W), .FETCH_TIMEOUT(15), .TMO_W(4)) dut (
    .Clk(Clk), .reset_n(reset_n), .Opcode(Opcode), .Z(Z), .C(C),
    .imem_ack(imem_ack), .resume(resume), .imem_req(imem_req), .LoadIR(LoadIR),
    .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC), .LoadReg(LoadReg),
    .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU), .halted(halted),
    .illegal_op(illegal_op)
  );

  always #5 Clk = ~Clk;

  function automatic logic [10:0] ctl();
    return {imem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, halted, illegal_op};
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench 1 ns into cycle 0 (first FETCH after release) with imem_ack = 1.
  task automatic do_reset();
    reset_n = 1'b0; imem_ack = 1'b1; resume = 1'b0; Z = 1'b0; C = 1'b0; Opcode = '0;
    repeat (2) @(posedge Clk);
    #1 reset_n = 1'b1;
  endtask

  // Runs one instruction from its FETCH cycle (ack already 1); returns FETCH and EXEC-slot observations.
  task automatic run_instr(input logic [3:0] op, input logic z, input logic c,
                           output logic [10:0] fobs, output logic [10:0] eobs,
                           output logic [OPC_W-1:0] alu);
    Opcode = OPC_W'(op);
    #1 fobs = ctl();
    next_cycle();
    next_cycle();
    Z = z; C = c;
    #1 eobs = ctl(); alu = SelALU;
    next_cycle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imem_ack = 1'b1; Opcode = OPC_W'(OP_ADD);
    #1;
    total++; if (ctl() !== 11'h000) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl(), 11'h000); end
    total++; if (SelALU !== OPC_W'(OP_NOP)) begin bad++; $display("FAIL reset_selalu: got %h want %h", SelALU, OP_NOP); end
    repeat (2) @(posedge Clk);
    #1;
    total++; if (ctl() !== 11'h000) begin bad++; $display("FAIL reset_clocked: got %b want %b", ctl(), 11'h000); end
    reset_n = 1'b1;
    #1;
    total++; if (ctl() !== V_FETCH_ACK) begin bad++; $display("FAIL reset_first_fetch: got %b want %b", ctl(), V_FETCH_ACK); end
  endtask

  task automatic test_add_halt();
    logic [10:0] f, e;
    logic [OPC_W-1:0] a;
    do_reset();
    run_instr(OP_ADD, 1'b0, 1'b0, f, e, a);
    total++; if (f !== V_FETCH_ACK) begin bad++; $display("FAIL add_fetch: got %b want %b", f, V_FETCH_ACK); end
    total++; if (e !== V_ALU) begin bad++; $display("FAIL add_exec: got %b want %b", e, V_ALU); end
    total++; if (a !== OPC_W'(OP_ADD)) begin bad++; $display("FAIL add_selalu: got %h want %h", a, OP_ADD); end
    run_instr(OP_HALT, 1'b0, 1'b0, f, e, a);
    total++; if (f !== V_FETCH_ACK) begin bad++; $display("FAIL halt_fetch: got %b want %b", f, V_FETCH_ACK); end
    total++; if (e !== B_HALT) begin bad++; $display("FAIL halt_enter: got %b want %b", e, B_HALT); end
    resume = 1'b1;
    #1;
    total++; if (ctl() !== B_HALT) begin bad++; $display("FAIL halt_hold: got %b want %b", ctl(), B_HALT); end
    next_cycle();
    resume = 1'b0;
    #1;
    total++; if (ctl() !== V_FETCH_ACK) begin bad++; $display("FAIL halt_resume: got %b want %b", ctl(), V_FETCH_ACK); end
  endtask

  task automatic test_jump(input logic zval);
    logic [10:0] f, e;
    logic [OPC_W-1:0] a;
    do_reset();
    run_instr(OP_IMM_TO_ACC, 1'b0, 1'b0, f, e, a);
    total++; if (e !== B_LDACC) begin bad++; $display("FAIL imm_to_acc z=%0b: got %b want %b", zval, e, B_LDACC); end
    run_instr(OP_SUB, zval, 1'b0, f, e, a);
    total++; if (a !== OPC_W'(OP_SUB)) begin bad++; $display("FAIL sub_selalu z=%0b: got %h want %h", zval, a, OP_SUB); end
    run_instr(OP_JMPZ_IMM, 1'b0, 1'b0, f, e, a);
    total++; if (e !== (zval ? V_JIMM : 11'h000)) begin bad++; $display("FAIL jmpz_imm z=%0b: got %b want %b", zval, e, zval ? V_JIMM : 11'h000); end
    total++; if (a !== (zval ? OPC_W'(OP_JMPZ_IMM) : OPC_W'(OP_NOP))) begin bad++; $display("FAIL jmpz_selalu z=%0b: got %h", zval, a); end
    run_instr(OP_REG_TO_ACC, ~zval, 1'b1, f, e, a);
    total++; if (e !== (B_LDACC | B_ACC_REG)) begin bad++; $display("FAIL reg_to_acc z=%0b: got %b want %b", zval, e, B_LDACC | B_ACC_REG); end
    run_instr(OP_JMPNZ_REG, 1'b0, 1'b0, f, e, a);
    total++; if (e !== (zval ? 11'h000 : B_LDPC)) begin bad++; $display("FAIL jmpnz_reg z=%0b: got %b want %b", zval, e, zval ? 11'h000 : B_LDPC); end
  endtask

  task automatic test_wait();
    int reqs, irs;
    reqs = 0; irs = 0;
    do_reset();
    imem_ack = 1'b0; Opcode = OPC_W'(OP_NOP);
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3);
      #1;
      reqs += int'(imem_req);
      irs  += int'(LoadIR);
      next_cycle();
    end
    #1;
    total++; if (ctl() !== 11'h000) begin bad++; $display("FAIL wait_decode: got %b want %b", ctl(), 11'h000); end
    total++; if (reqs !== 4) begin bad++; $display("FAIL wait_req_cycles: got %0d want 4", reqs); end
    total++; if (irs !== 1) begin bad++; $display("FAIL wait_loadir_pulses: got %0d want 1", irs); end
  endtask

  task automatic test_timeout();
    int reqs;
    reqs = 0;
    do_reset();
    imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1 reqs += int'(imem_req);
      next_cycle();
    end
    #1;
    total++; if (reqs !== 15) begin bad++; $display("FAIL tmo_req_cycles: got %0d want 15", reqs); end
    total++; if (ctl() !== B_ILL) begin bad++; $display("FAIL tmo_trap: got %b want %b", ctl(), B_ILL); end
    imem_ack = 1'b1; resume = 1'b1;
    repeat (3) next_cycle();
    resume = 1'b0;
    total++; if (ctl() !== B_ILL) begin bad++; $display("FAIL tmo_sticky: got %b want %b", ctl(), B_ILL); end
    reset_n = 1'b0;
    #1;
    total++; if (ctl() !== 11'h000) begin bad++; $display("FAIL tmo_reset_clear: got %b want %b", ctl(), 11'h000); end
  endtask

  task automatic test_opcode9();
    logic [10:0] f, e;
    logic [OPC_W-1:0] a;
    do_reset();
`ifdef CTRL_CARRY_JUMPS_EN
    run_instr(OP_ADD, 1'b0, 1'b1, f, e, a);
    run_instr(4'h9, 1'b0, 1'b0, f, e, a);
    total++; if (e !== V_JIMM) begin bad++; $display("FAIL jmpc_taken: got %b want %b", e, V_JIMM); end
    total++; if (a !== OPC_W'(4'h9)) begin bad++; $display("FAIL jmpc_selalu: got %h want 9", a); end
    run_instr(4'hE, 1'b0, 1'b0, f, e, a);
    total++; if (e !== 11'h000) begin bad++; $display("FAIL jmpnc_not_taken: got %b want %b", e, 11'h000); end
`else
    run_instr(4'h9, 1'b0, 1'b0, f, e, a);
    total++; if (e !== B_ILL) begin bad++; $display("FAIL op9_trap: got %b want %b", e, B_ILL); end
    total++; if (ctl() !== B_ILL) begin bad++; $display("FAIL op9_sticky: got %b want %b", ctl(), B_ILL); end
`endif
  endtask

  task automatic test_reset_mid_exec();
    logic [10:0] f, e;
    logic [OPC_W-1:0] a;
    do_reset();
    run_instr(OP_ADD, 1'b1, 1'b1, f, e, a);
    Opcode = OPC_W'(OP_ACC_TO_REG);
    next_cycle();
    next_cycle();
    total++; if (ctl() !== B_LDREG) begin bad++; $display("FAIL a2r_exec: got %b want %b", ctl(), B_LDREG); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (ctl() !== 11'h000) begin bad++; $display("FAIL a2r_async_reset: got %b want %b", ctl(), 11'h000); end
    @(posedge Clk);
    #1 reset_n = 1'b1;
    #1;
    total++; if (ctl() !== V_FETCH_ACK) begin bad++; $display("FAIL a2r_release_fetch: got %b want %b", ctl(), V_FETCH_ACK); end
    run_instr(OP_JMPNZ_IMM, 1'b0, 1'b0, f, e, a);
    total++; if (e !== V_JIMM) begin bad++; $display("FAIL zf_cleared: got %b want %b", e, V_JIMM); end
    total++; if (a !== OPC_W'(OP_JMPNZ_IMM)) begin bad++; $display("FAIL zf_cleared_selalu: got %h want %h", a, OP_JMPNZ_IMM); end
`ifdef CTRL_CARRY_JUMPS_EN
    run_instr(4'h9, 1'b0, 1'b0, f, e, a);
    total++; if (e !== 11'h000) begin bad++; $display("FAIL cf_cleared: got %b want %b", e, 11'h000); end
`endif
  endtask

  initial begin
    test_reset();
    test_add_halt();
    test_jump(1'b1);
    test_jump(1'b0);
    test_wait();
    test_timeout();
    test_opcode9();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
